// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: valid/ready word load, LSB-first shift-out on shift_en strobes.
// Define PISO_PARITY_EN to append one even-parity bit after the last data bit.
module piso_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_done;
   logic             w_load;
   logic             w_step;
   logic             w_end;
`ifdef PISO_PARITY_EN
   logic             r_par;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      w_end  = 1'b0;
      case (r_state)
         IDLE: begin
            if (load_valid) begin
               w_load = 1'b1;
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               w_step = 1'b1;
               if (r_cnt == LAST) begin
`ifdef PISO_PARITY_EN
                  w_next = PARITY;
`else
                  w_next = IDLE;
                  w_end  = 1'b1;
`endif
               end
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            if (shift_en) begin
               w_next = IDLE;
               w_end  = 1'b1;
            end
         end
`endif
         default: w_next = IDLE;
      endcase
   end

   // Counter stops at LAST so it never wraps, even between frames.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_end;
         if (w_load) begin
            r_shift <= load_data;
            r_cnt   <= '0;
         end else if (w_step) begin
            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
         end
      end
   end

`ifdef PISO_PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_par <= 1'b0;
      else if (w_load) r_par <= ^load_data;
   end
`endif

   // Outputs decode registered state only; no input reaches an output combinationally.
   always_comb begin
      load_ready = (r_state == IDLE);
      busy       = (r_state != IDLE);
      sout_valid = (r_state != IDLE);
      frame_done = r_done;
      sout       = 1'b0;
      case (r_state)
         SHIFT:   sout = r_shift[0];
`ifdef PISO_PARITY_EN
         PARITY:  sout = r_par;
`endif
         default: sout = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer; expected serial bits are queued at load and popped per strobe.
// Follows PISO_PARITY_EN the same way the design does.
module tb_piso_serializer;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk;
   logic         reset_n;
   logic         load_valid;
   logic         load_ready;
   logic [W-1:0] load_data;
   logic         shift_en;
   logic         sout;
   logic         sout_valid;
   logic         busy;
   logic         frame_done;

   int   checks   = 0;
   int   failures = 0;
   logic q[$];

   piso_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .shift_en   (shift_en),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bits(input logic [W-1:0] d);
      for (int i = 0; i < W; i++) q.push_back(d[i]);
`ifdef PISO_PARITY_EN
      q.push_back(^d);
`endif
   endtask

   // Handshake at the next edge; returns in the first frame cycle.
   task automatic do_load(input logic [W-1:0] d);
      chk("load_ready_before_load", load_ready, 1'b1);
      load_valid = 1'b1;
      load_data  = d;
      push_bits(d);
      tick();
      load_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_load_ready"}, load_ready, 1'b1);
      chk({tag, "_busy"},       busy,       1'b0);
      chk({tag, "_sout"},       sout,       1'b0);
      chk({tag, "_sout_valid"}, sout_valid, 1'b0);
      chk({tag, "_frame_done"}, frame_done, 1'b0);
   endtask

   // Scoreboard: every frame bit must match the queue head; a strobe consumes it.
   always @(negedge clk) begin
      logic e;
      if (reset_n && sout_valid) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_bit", sout_valid, 1'b0);
         end else begin
            chk("sout_bit", sout, q[0]);
            if (shift_en) e = q.pop_front();
         end
      end
   end

   initial begin
      reset_n    = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      shift_en   = 1'b0;
      #1;
      chk_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();

      // Continuous strobe, 0xA5
      shift_en = 1'b1;
      do_load(8'hA5);
      for (int c = 1; c <= FL; c++) begin
         chk("a5_sout_valid", sout_valid, 1'b1);
         chk("a5_load_ready", load_ready, 1'b0);
         chk("a5_busy",       busy,       1'b1);
         chk("a5_frame_done", frame_done, 1'b0);
         tick();
      end
      chk("a5_done_pulse",   frame_done, 1'b1);
      chk("a5_ready_after",  load_ready, 1'b1);
      chk("a5_valid_after",  sout_valid, 1'b0);
      tick();
      chk("a5_done_cleared", frame_done, 1'b0);

      // 0x07 (parity bit 1 when enabled)
      do_load(8'h07);
      repeat (FL) tick();
      chk("x07_done_pulse", frame_done, 1'b1);
      tick();

      // Strobe 1-of-3 cycles, 0x3C
      shift_en = 1'b0;
      do_load(8'h3C);
      for (int s = 0; s < FL; s++) begin
         chk("x3c_busy",       busy,       1'b1);
         chk("x3c_frame_done", frame_done, 1'b0);
         shift_en = 1'b0;
         tick();
         tick();
         shift_en = 1'b1;
         tick();
      end
      shift_en = 1'b0;
      chk("x3c_done_pulse", frame_done, 1'b1);
      chk("x3c_idle",       busy,       1'b0);
      tick();
      chk("x3c_done_cleared", frame_done, 1'b0);

      // load_valid held: 0x11 intact, 0xFF captured in the frame_done cycle
      shift_en   = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h11;
      push_bits(8'h11);
      tick();
      load_data = 8'hFF;
      for (int c = 1; c <= FL; c++) begin
         chk("b2b_ready_low", load_ready, 1'b0);
         tick();
      end
      chk("b2b_done_pulse", frame_done, 1'b1);
      chk("b2b_idle_ready", load_ready, 1'b1);
      push_bits(8'hFF);
      tick();
      load_valid = 1'b0;
      chk("b2b_second_start", sout_valid, 1'b1);
      chk("b2b_done_cleared", frame_done, 1'b0);
      repeat (FL - 1) tick();
      chk("b2b_second_last", sout_valid, 1'b1);
      tick();
      chk("b2b_second_done", frame_done, 1'b1);
      tick();

      // Asynchronous reset during bit 4
      do_load(8'h5A);
      repeat (4) tick();
      chk("rst_mid_frame_valid", sout_valid, 1'b1);
      #3;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("rst_async");
      q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("rst_no_done",  frame_done, 1'b0);
      chk("rst_ready",    load_ready, 1'b1);
      tick();
      chk("rst_no_done2", frame_done, 1'b0);
      do_load(8'h81);
      repeat (FL) tick();
      chk("x81_done_pulse", frame_done, 1'b1);
      tick();

      // Strobes in IDLE are ignored
      shift_en   = 1'b1;
      load_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         chk("idle_sout_valid", sout_valid, 1'b0);
         chk("idle_sout",       sout,       1'b0);
         chk("idle_frame_done", frame_done, 1'b0);
         tick();
      end
      shift_en = 1'b0;

      chk("sb_drained", (q.size() == 0), 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
